// File: rtl/wb_stage_param.sv
// wb_stage_param: parametrised RISC-V write-back stage.
// Selects the result source (ALU, formatted load, PC+4, CSR), formats loads,
// and suppresses writes to x0. Supports stall/flush and reports retirement.
// All outputs are registered, with a latency of one clock edge.
// Optional macro WB_INSTRET_EN adds a 64-bit retired-instruction counter o_instret.
module wb_stage_param #(
  parameter int unsigned XLEN       = 64,
  parameter bit          ZERO_GUARD = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            i_valid,
  input  logic [31:0]     i_instruction,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_csr_data,
  input  logic            i_reg_write,
  input  logic [1:0]      i_wb_sel,
  output logic [4:0]      o_rd_index,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_rd_we,
  output logic            o_valid
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]     o_instret
`endif
);

  localparam int unsigned OFF_W = $clog2(XLEN / 8);
  localparam int unsigned SH_W  = OFF_W + 3;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_PC4  = 2'd2;
  localparam logic [1:0] SEL_CSR  = 2'd3;

  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [OFF_W-1:0] off;
  logic [OFF_W-1:0] off_h;
  logic [OFF_W-1:0] off_w;
  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;
  logic [XLEN-1:0] word_sh;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wb_data;
  logic            wb_we;

  logic [4:0]      rd_index_q, rd_index_d;
  logic [XLEN-1:0] rd_data_q,  rd_data_d;
  logic            rd_we_q,    rd_we_d;
  logic            valid_q,    valid_d;
`ifdef WB_INSTRET_EN
  logic [63:0]     instret_q,  instret_d;
`endif

  assign rd     = i_instruction[11:7];
  assign funct3 = i_instruction[14:12];

  // Load extraction: shift the addressed byte/half/word down to bit 0, then extend.
  always_comb begin
    off     = i_alu_result[OFF_W-1:0];
    off_h   = off & ~OFF_W'(1);
    off_w   = off & ~OFF_W'(3);
    byte_sh = i_mem_data >> {off,   3'b000};
    half_sh = i_mem_data >> {off_h, 3'b000};
    word_sh = i_mem_data >> {off_w, 3'b000};
    load_data = i_mem_data;
    unique case (funct3)
      3'd0: load_data = XLEN'($signed(byte_sh[7:0]));
      3'd4: load_data = XLEN'(byte_sh[7:0]);
      3'd1: load_data = XLEN'($signed(half_sh[15:0]));
      3'd5: load_data = XLEN'(half_sh[15:0]);
      3'd2: load_data = XLEN'($signed(word_sh[31:0]));
      3'd6: begin
        // On RV32 there is nothing to zero-extend into, so LWU behaves as LW.
        if (XLEN == 64) load_data = XLEN'(word_sh[31:0]);
        else            load_data = XLEN'($signed(word_sh[31:0]));
      end
      3'd3: begin
        // LD is only meaningful on RV64; RV32 treats it as LW.
        if (XLEN == 64) load_data = i_mem_data;
        else            load_data = XLEN'($signed(word_sh[31:0]));
      end
      default: load_data = i_mem_data;
    endcase
  end

  // Result source mux and write-enable qualification.
  always_comb begin
    wb_data = i_alu_result;
    unique case (i_wb_sel)
      SEL_ALU:  wb_data = i_alu_result;
      SEL_LOAD: wb_data = load_data;
      SEL_PC4:  wb_data = i_pc + XLEN'(4);
      SEL_CSR:  wb_data = i_csr_data;
      default:  wb_data = i_alu_result;
    endcase
    wb_we = i_valid & i_reg_write & ~(ZERO_GUARD & (rd == 5'd0));
  end

  // Next-state: flush kills the instruction, stall holds, otherwise capture.
  always_comb begin
    rd_index_d = rd_index_q;
    rd_data_d  = rd_data_q;
    rd_we_d    = rd_we_q;
    valid_d    = valid_q;
`ifdef WB_INSTRET_EN
    instret_d  = instret_q;
`endif
    if (i_flush) begin
      rd_index_d = rd;
      rd_data_d  = wb_data;
      rd_we_d    = 1'b0;
      valid_d    = 1'b0;
    end else if (!i_stall) begin
      rd_index_d = rd;
      rd_data_d  = wb_data;
      rd_we_d    = wb_we;
      valid_d    = i_valid;
`ifdef WB_INSTRET_EN
      instret_d  = instret_q + 64'(i_valid);
`endif
    end
  end

  // Output registers with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_index_q <= '0;
      rd_data_q  <= '0;
      rd_we_q    <= 1'b0;
      valid_q    <= 1'b0;
`ifdef WB_INSTRET_EN
      instret_q  <= '0;
`endif
    end else begin
      rd_index_q <= rd_index_d;
      rd_data_q  <= rd_data_d;
      rd_we_q    <= rd_we_d;
      valid_q    <= valid_d;
`ifdef WB_INSTRET_EN
      instret_q  <= instret_d;
`endif
    end
  end

  assign o_rd_index = rd_index_q;
  assign o_rd_data  = rd_data_q;
  assign o_rd_we    = rd_we_q;
  assign o_valid    = valid_q;
`ifdef WB_INSTRET_EN
  assign o_instret  = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage_param.sv
// Self-checking bench for wb_stage_param (XLEN = 64, ZERO_GUARD = 1).
// Directed cases from the block's test plan plus a randomized run against a
// byte-array reference model. Counter checks apply when WB_INSTRET_EN is defined.
module tb_wb_stage_param;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        valid;
  logic [31:0] instr;
  logic [63:0] alu;
  logic [63:0] mem;
  logic [63:0] pc;
  logic [63:0] csr;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic [4:0]  rd_index;
  logic [63:0] rd_data;
  logic        rd_we;
  logic        o_vld;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
  logic [63:0] exp_instret;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Expected registered state kept by the bench.
  logic [4:0]  exp_idx;
  logic [63:0] exp_data;
  logic        exp_we;
  logic        exp_vld;

  wb_stage_param #(.XLEN(64), .ZERO_GUARD(1'b1)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_stall       (stall),
    .i_flush       (flush),
    .i_valid       (valid),
    .i_instruction (instr),
    .i_alu_result  (alu),
    .i_mem_data    (mem),
    .i_pc          (pc),
    .i_csr_data    (csr),
    .i_reg_write   (reg_write),
    .i_wb_sel      (wb_sel),
    .o_rd_index    (rd_index),
    .o_rd_data     (rd_data),
    .o_rd_we       (rd_we),
    .o_valid       (o_vld)
`ifdef WB_INSTRET_EN
    ,
    .o_instret     (instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: pick bytes out of a little-endian byte array and extend.
  function automatic logic [63:0] ref_data(input logic [1:0] sel, input logic [2:0] f3,
                                           input logic [63:0] a, input logic [63:0] m,
                                           input logic [63:0] p, input logic [63:0] c);
    logic [7:0]  b [8];
    int          n;
    int          start;
    logic [63:0] v;
    if (sel == 2'd0) return a;
    if (sel == 2'd2) return p + 64'd4;
    if (sel == 2'd3) return c;
    if (f3 == 3'd7 || f3 == 3'd3) return m;
    for (int k = 0; k < 8; k++) b[k] = m[8*k +: 8];
    n = 1 << f3[1:0];
    start = int'(a[2:0]) & ~(n - 1);
    v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = b[start + k];
    if (!f3[2] && v[8*n - 1]) for (int k = 8*n; k < 64; k++) v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd);
    logic [31:0] w;
    w = 32'h0000_0003;
    w[14:12] = f3;
    w[11:7]  = rd;
    return w;
  endfunction

  task automatic drive(input logic v, input logic rw, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [63:0] a, input logic [63:0] m,
                       input logic [63:0] p, input logic [63:0] c,
                       input logic st, input logic fl);
    valid = v; reg_write = rw; wb_sel = sel; instr = mk_instr(f3, rd);
    alu = a; mem = m; pc = p; csr = c; stall = st; flush = fl;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 3'd0, 5'd0, '0, '0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b1, 1'b1, 2'd0, 3'd0, 5'd9, 64'hDEAD, '0, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rd_index !== 5'd0 || rd_data !== 64'd0 || rd_we !== 1'b0 || o_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: idx=%0d data=%h we=%b vld=%b, required all zero",
               rd_index, rd_data, rd_we, o_vld);
    end
`ifdef WB_INSTRET_EN
    n_checks++;
    if (instret !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_instret: got %0d, required 0", instret);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 2'd0, 3'd0, 5'd5, 64'h1234, '0, '0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (rd_index !== 5'd5 || rd_data !== 64'h1234 || rd_we !== 1'b1 || o_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL first_capture: idx=%0d data=%h we=%b vld=%b, required 5 1234 1 1",
               rd_index, rd_data, rd_we, o_vld);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [6] = '{3'd0, 3'd4, 3'd1, 3'd6, 3'd2, 3'd3};
    logic [63:0] offs [6] = '{64'd1, 64'd1, 64'd0, 64'd4, 64'd4, 64'd0};
    logic [63:0] exps [6] = '{64'hFFFF_FFFF_FFFF_FFF2, 64'h0000_0000_0000_00F2,
                              64'hFFFF_FFFF_FFFF_F2F1, 64'h0000_0000_8877_6655,
                              64'hFFFF_FFFF_8877_6655, 64'h8877_6655_4433_F2F1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 2'd1, f3s[i], 5'd10, offs[i], 64'h8877_6655_4433_F2F1,
            '0, '0, 1'b0, 1'b0);
      @(posedge clk); #1;
      n_checks++;
      if (rd_data !== exps[i] || rd_we !== 1'b1) begin
        n_fail++;
        $display("FAIL load_f3_%0d: data=%h we=%b, required %h 1", f3s[i], rd_data, rd_we, exps[i]);
      end
    end
  endtask

  task automatic test_pc_csr();
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd2, 3'd0, 5'd1, '0, '0, 64'hFFFF_FFFF_FFFF_FFFC, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (rd_data !== 64'd0) begin
      n_fail++;
      $display("FAIL pc4_wrap: data=%h, required 0", rd_data);
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd3, 3'd0, 5'd2, '0, '0, '0, 64'hABC, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (rd_data !== 64'hABC || rd_index !== 5'd2) begin
      n_fail++;
      $display("FAIL csr: data=%h idx=%0d, required abc 2", rd_data, rd_index);
    end
  endtask

  task automatic test_x0_guard();
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd0, 3'd0, 5'd0, 64'h77, '0, '0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (rd_we !== 1'b0 || o_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_valid: we=%b vld=%b, required 0 1", rd_we, o_vld);
    end
    @(negedge clk);
    drive(1'b0, 1'b1, 2'd0, 3'd0, 5'd0, 64'h77, '0, '0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (rd_we !== 1'b0 || o_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_invalid: we=%b vld=%b, required 0 0", rd_we, o_vld);
    end
  endtask

  task automatic test_stall_flush();
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd0, 3'd0, 5'd7, 64'h55, '0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom), 5'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, '0, '0, 1'b1, 1'b0);
      @(posedge clk); #1;
      n_checks++;
      if (rd_index !== 5'd7 || rd_data !== 64'h55 || rd_we !== 1'b1 || o_vld !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: idx=%0d data=%h we=%b vld=%b, required 7 55 1 1",
                 i, rd_index, rd_data, rd_we, o_vld);
      end
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd0, 3'd0, 5'd8, 64'h66, '0, '0, '0, 1'b1, 1'b1);
    @(posedge clk); #1;
    n_checks++;
    if (rd_we !== 1'b0 || o_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_flush: we=%b vld=%b, required 0 0", rd_we, o_vld);
    end
  endtask

`ifdef WB_INSTRET_EN
  task automatic test_instret();
    do_reset();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 2'd0, 3'd0, 5'd3, 64'(i), '0, '0, '0, i == 4 || i == 7, i == 10);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 3'd0, 5'd0, '0, '0, '0, '0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (instret !== 64'd10) begin
      n_fail++;
      $display("FAIL instret_count: got %0d, required 10", instret);
    end
    force dut.instret_q = '1;
    #1;
    release dut.instret_q;
    drive(1'b1, 1'b1, 2'd0, 3'd0, 5'd3, '0, '0, '0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (instret !== 64'd0) begin
      n_fail++;
      $display("FAIL instret_wrap: got %0d, required 0", instret);
    end
  endtask
`endif

  task automatic test_random();
    logic v, rw, st, fl;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [63:0] a, m, p, c;
    do_reset();
    exp_idx = '0; exp_data = '0; exp_we = 1'b0; exp_vld = 1'b0;
`ifdef WB_INSTRET_EN
    exp_instret = '0;
`endif
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      v = 1'($urandom); rw = 1'($urandom); sel = 2'($urandom); f3 = 3'($urandom);
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      a = {$urandom, $urandom}; m = {$urandom, $urandom};
      p = {$urandom, $urandom}; c = {$urandom, $urandom};
      st = ($urandom_range(0, 4) == 0); fl = ($urandom_range(0, 6) == 0);
      drive(v, rw, sel, f3, rd, a, m, p, c, st, fl);
      if (fl) begin
        exp_idx = rd; exp_data = ref_data(sel, f3, a, m, p, c); exp_we = 1'b0; exp_vld = 1'b0;
      end else if (!st) begin
        exp_idx = rd; exp_data = ref_data(sel, f3, a, m, p, c);
        exp_we = v && rw && rd != 0; exp_vld = v;
`ifdef WB_INSTRET_EN
        if (v) exp_instret = exp_instret + 1;
`endif
      end
      @(posedge clk); #1;
      n_checks++;
      if (rd_index !== exp_idx || rd_data !== exp_data || rd_we !== exp_we || o_vld !== exp_vld) begin
        n_fail++;
        $display("FAIL random_%0d: idx=%0d data=%h we=%b vld=%b, required %0d %h %b %b",
                 i, rd_index, rd_data, rd_we, o_vld, exp_idx, exp_data, exp_we, exp_vld);
      end
`ifdef WB_INSTRET_EN
      n_checks++;
      if (instret !== exp_instret) begin
        n_fail++;
        $display("FAIL random_instret_%0d: got %0d, required %0d", i, instret, exp_instret);
      end
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 3'd0, 5'd0, '0, '0, '0, '0, 1'b0, 1'b0);
    test_reset();
    test_loads();
    test_pc_csr();
    test_x0_guard();
    test_stall_flush();
`ifdef WB_INSTRET_EN
    test_instret();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage_param.md
Name: wb_stage_param

Overview:
- Parametrised RISC-V write-back stage; successor of the fixed 64-bit ALU/MEM write-back register.
- Sits between the MEM stage and the register file.
- Selects the result source: ALU, formatted load, PC+4 or CSR.
- Performs load byte/half/word extraction with sign/zero extension and suppresses x0 writes.
- Supports stall and flush, and reports retirement.
- All outputs are registered; latency is one i_clk edge.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- ZERO_GUARD, 1, when 1 any write targeting rd = 0 is dropped (o_rd_we forced 0).

Ports:
- i_clk  in  1  rising-edge clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_stall  in  1  hold all registered outputs.
- i_flush  in  1  kill the instruction being captured.
- i_valid  in  1  MEM stage presents a real instruction.
- i_instruction  in  32  instruction word; uses rd = [11:7] and funct3 = [14:12].
- i_alu_result  in  XLEN  ALU result; low bits also give the load byte offset.
- i_mem_data  in  XLEN  naturally aligned XLEN-wide memory word containing the load.
- i_pc  in  XLEN  PC of the instruction.
- i_csr_data  in  XLEN  CSR read data.
- i_reg_write  in  1  instruction writes rd.
- i_wb_sel  in  2  source select: 0 ALU, 1 load, 2 PC+4, 3 CSR.
- o_rd_index  out  5  destination register.
- o_rd_data  out  XLEN  write-back data.
- o_rd_we  out  1  register-file write enable.
- o_valid  out  1  one instruction retired this cycle.
- o_instret  out  64  retired-instruction count (optional feature only).

Behaviour:
- Reset (i_rst_n low, asynchronous): o_rd_index = 0, o_rd_data = 0, o_rd_we = 0, o_valid = 0, o_instret = 0. Reset takes effect immediately, mid-stall included; first capture is on the first rising edge after deassertion.
- Priority on each rising edge: flush > stall > capture.
- Flush: o_rd_we = 0 and o_valid = 0. o_rd_index and o_rd_data are still loaded with the computed values (don't-care to consumers).
- Stall (no flush): every output holds its value, including o_rd_we. The register file must tolerate a repeated identical write.
- Capture:
  - o_rd_index = i_instruction[11:7].
  - o_rd_data = selected source (see below).
  - o_valid = i_valid.
  - o_rd_we = i_valid & i_reg_write & !(ZERO_GUARD & rd == 0).
- Source select:
  - 0: i_alu_result.
  - 2: i_pc + 4, modulo 2^XLEN (wrap-around permitted).
  - 3: i_csr_data.
  - 1: load formatting, below.
- Load formatting:
  - Byte offset off = i_alu_result[log2(XLEN/8)-1:0].
  - funct3 0 LB: byte at off, sign-extended.
  - funct3 4 LBU: byte at off, zero-extended.
  - funct3 1 LH / 5 LHU: halfword at off with off[0] ignored; sign- / zero-extended.
  - funct3 2 LW / 6 LWU: word at off with off[1:0] ignored; sign- / zero-extended.
  - funct3 3 LD: full XLEN word. XLEN = 64 only.
  - XLEN = 32: funct3 3 behaves as LW and 6 as LW. No misalignment trap is raised here.
  - funct3 7: o_rd_data = i_mem_data unmodified.
- Byte numbering is little-endian: byte k = i_mem_data[8k+7:8k].
- x0 with ZERO_GUARD = 0: o_rd_we follows i_reg_write; the register file is responsible for discarding.
- i_valid = 0: o_rd_we = 0 and o_valid = 0 regardless of i_reg_write.

Optional Feature:
- Macro: WB_INSTRET_EN.
- Defined:
  - o_instret is present. It is a 64-bit counter that increments by 1 on each rising edge where the capture path is taken (no flush, no stall) and i_valid = 1.
  - Wraps from 2^64-1 to 0. Reset value is 0.
  - Holds during stall; does not count flushed instructions.
- Undefined: port o_instret and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert i_rst_n = 0 mid-cycle with outputs non-zero -> all outputs 0 immediately, before the next edge. Release, present ALU op rd = 5, i_alu_result = 0x1234, i_reg_write = 1, i_valid = 1 -> next edge o_rd_index = 5, o_rd_data = 0x1234, o_rd_we = 1, o_valid = 1.
- Loads, XLEN = 64, i_mem_data = 0x8877_6655_4433_F2F1:
  - LB, off = 1 -> 0xFFFF_FFFF_FFFF_FFF2.
  - LBU, off = 1 -> 0xF2.
  - LH, off = 0 -> 0xFFFF_FFFF_FFFF_F2F1.
  - LWU, off = 4 -> 0x8877_6655.
  - LW, off = 4 -> 0xFFFF_FFFF_8877_6655.
  - LD -> 0x8877_6655_4433_F2F1.
- PC+4 and CSR: i_wb_sel = 2 with i_pc = 0xFFFF_FFFF_FFFF_FFFC -> o_rd_data = 0. i_wb_sel = 3 with i_csr_data = 0xABC -> 0xABC.
- x0 guard: rd = 0, i_reg_write = 1, i_valid = 1 -> o_rd_we = 0, o_valid = 1. Same with i_valid = 0 -> o_rd_we = 0, o_valid = 0.
- Stall/flush:
  - Capture rd = 7, data 0x55, then hold i_stall = 1 for 3 cycles with changing inputs -> outputs stay rd = 7, 0x55, we = 1.
  - Assert i_stall and i_flush together -> next edge o_rd_we = 0, o_valid = 0.
- WB_INSTRET_EN: 10 valid captures, 2 stalled cycles, 1 flush -> o_instret = 10. Force the counter to 2^64-1 then one valid capture -> 0.
